dsp_post_adder_accum: RTL
=========================

Name: dsp_post_adder_accum

Overview:
- Post-adder/accumulator stage of the DSP48A1 slice model. Sits directly downstream of the M (multiplier) pipeline register and the C/D/A/B operand registers.
- Selects X and Z operands per OPMODE and adds or subtracts them with carry-in.
- Drives the P, PCOUT and CARRYOUT outputs, with optional output registering and self-feedback for multiply-accumulate.

Parameters:
- WIDTH, 48: post-adder/P width. Fixed at 48 for the DSP48A1 and only checked at that value.
- M_WIDTH, 36: multiplier product width, zero-extended into X.
- PREG, 1: 1 means the P output is taken from the P register; 0 means P is the combinational adder result.
- CARRYOUTREG, 1: 1 means the CARRYOUT output is registered; 0 means it is combinational.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk only
- cep  in  1  clock enable for the P register
- cecarryin  in  1  clock enable for the carry-out register
- opmode  in  8  registered OPMODE from upstream: [1:0] X select, [3:2] Z select, [7] subtract
- m  in  M_WIDTH  registered multiplier product
- dab  in  48  concatenation {D[11:0], A[17:0], B[17:0]}
- c  in  48  registered C operand
- pcin  in  48  cascade input from the previous slice
- cin  in  1  registered carry-in (CYI output)
- p  out  48  post-adder result
- pcout  out  48  cascade output, always equal to p
- carryout  out  1  carry/borrow out of bit 47
- carryoutf  out  1  fabric copy of carryout, always equal to it

Behaviour:
- Internal registers p_q[47:0] and co_q always exist. X/Z feedback always reads p_q, never the combinational result, so no loop exists for any PREG value.
- X mux, opmode[1:0]:
  - 0 selects 48'h0
  - 1 selects {12'h0, m}
  - 2 selects p_q
  - 3 selects dab
- Z mux, opmode[3:2]:
  - 0 selects 48'h0
  - 1 selects pcin
  - 2 selects p_q
  - 3 selects c
- Arithmetic is 49-bit unsigned:
  - opmode[7]=0: sum = {0,Z} + {0,X} + cin
  - opmode[7]=1: sum = {0,Z} − ({0,X} + cin), with the inner add done at 49 bits
  - Result is sum[47:0]; carry = sum[48]. For subtract, carry=1 indicates borrow.
- opmode[6:4] are ignored by this block.
- On rising clk:
  - if rst_n=0: p_q←0 and co_q←0.
  - else: if cep, p_q←result; if cecarryin, co_q←carry.
  - Reset has priority over both enables. The enables are independent.
- Output selection:
  - p/pcout = PREG ? p_q : result
  - carryout/carryoutf = CARRYOUTREG ? co_q : carry
- Latency: 1 clk from the operand change to p when PREG=1; 0 clk when PREG=0.
- Reset values: with PREG=1 and CARRYOUTREG=1, all outputs are 0 in the cycle after reset. In combinational modes, outputs follow the current inputs.
- Feedback still uses p_q when PREG=0, so accumulation with PREG=0 requires cep=1.
- Wrap-around: overflow of 48 bits wraps modulo 2^48, with carry=1. No saturation.
- Reset mid-accumulation: p_q clears on that edge; the next cycle's accumulation starts from 0.
- cep=0 holds p_q. p (PREG=1) stays stable even while opmode or operands change.
- X=P with Z=P is legal: it computes 2·p_q + cin.

Decomposition:
- Shared package dsp48a1_pkg holds:
  - OPMODE field constants: OPM_X_LSB=0, OPM_Z_LSB=2, OPM_SUB=7
  - X-select encodings: X_ZERO, X_M, X_P, X_DAB
  - Z-select encodings: Z_ZERO, Z_PCIN, Z_P, Z_C
  - P_WIDTH=48
- One sub-module, dsp_pipe_reg: a parameterized width register with CE and sync active-low reset. It is instantiated twice, once for p_q (48 bits) and once for co_q (1 bit).

Test Plan:
- Reset: rst_n=0 for 2 clk with cep=1 and arbitrary operands → p=0, carryout=0. Release → p follows the operands next clk.
- MAC: opmode=8'h09 (X=M, Z=P), m=5, cin=0, cep=1, 4 clk → p = 5, 10, 15, 20 on successive clks. Then cep=0 for 2 clk → p holds 20.
- Wrap: opmode=8'h0F (X=DAB, Z=C), c=48'hFFFF_FFFF_FFFF, dab=1 → p=0, carryout=1 after 1 clk (CARRYOUTREG=1, cecarryin=1).
- Subtract with borrow: opmode=8'h8D (sub, X=M, Z=C), c=10, m=3, cin=1 → p=6, carryout=0. Then c=2 → p=48'hFFFF_FFFF_FFFE, carryout=1.
- Bypass (PREG=0, CARRYOUTREG=0): opmode=8'h07 (X=DAB, Z=PCIN), pcin=100, dab=23 → p=123 in the same cycle. pcout and carryoutf mirror p and carryout.
- Reset mid-accumulation: MAC with m=7 for 3 clk (p=21), then rst_n=0 for 1 clk → p=0. After release → p=7 at the next edge.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// ============================================================================
// dsp48a1_pkg
// Shared OPMODE field positions and X/Z operand-select encodings.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dsp48a1_pkg;

    localparam int P_WIDTH   = 48;

    localparam int OPM_X_LSB = 0;
    localparam int OPM_Z_LSB = 2;
    localparam int OPM_SUB   = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } xsel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } zsel_e;

endpackage

`default_nettype wire

// File: rtl/dsp_pipe_reg.sv
// ============================================================================
// dsp_pipe_reg
// Width-parameterized pipeline register with clock enable and sync reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dsp_pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Reset wins over the enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (ce_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/dsp_post_adder_accum.sv
// ============================================================================
// dsp_post_adder_accum
// DSP48A1 post-adder/accumulator: X/Z operand muxing, add/sub with carry-in,
// optional P and carry-out registering, P self-feedback for MAC.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dsp_post_adder_accum
    import dsp48a1_pkg::*;
#(
    parameter int WIDTH       = P_WIDTH,
    parameter int M_WIDTH     = 36,
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cep,
    input  logic               cecarryin,
    input  logic [7:0]         opmode,
    input  logic [M_WIDTH-1:0] m,
    input  logic [WIDTH-1:0]   dab,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   pcin,
    input  logic               cin,
    output logic [WIDTH-1:0]   p,
    output logic [WIDTH-1:0]   pcout,
    output logic               carryout,
    output logic               carryoutf
);

    xsel_e              x_sel;
    zsel_e              z_sel;
    logic [WIDTH-1:0]   x_mux;
    logic [WIDTH-1:0]   z_mux;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   p_d;
    logic               co_d;
    logic [WIDTH-1:0]   p_q;
    logic               co_q;
    logic               unused_opmode;

    assign x_sel = xsel_e'(opmode[OPM_X_LSB +: 2]);
    assign z_sel = zsel_e'(opmode[OPM_Z_LSB +: 2]);

    // Feedback always reads p_q, so no combinational loop exists for PREG=0.
    always_comb begin
        x_mux = '0;
        case (x_sel)
            X_ZERO:  x_mux = '0;
            X_M:     x_mux = {{(WIDTH-M_WIDTH){1'b0}}, m};
            X_P:     x_mux = p_q;
            X_DAB:   x_mux = dab;
            default: x_mux = '0;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (z_sel)
            Z_ZERO:  z_mux = '0;
            Z_PCIN:  z_mux = pcin;
            Z_P:     z_mux = p_q;
            Z_C:     z_mux = c;
            default: z_mux = '0;
        endcase
    end

    // Subtract folds cin into X first; bit WIDTH then reads as a borrow.
    always_comb begin
        sum = '0;
        if (opmode[OPM_SUB]) begin
            sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{WIDTH{1'b0}}, cin});
        end else begin
            sum = {1'b0, z_mux} + {1'b0, x_mux} + {{WIDTH{1'b0}}, cin};
        end
    end

    assign p_d  = sum[WIDTH-1:0];
    assign co_d = sum[WIDTH];

    assign unused_opmode = &{1'b0, opmode[6:4]};

    dsp_pipe_reg #(
        .WIDTH (WIDTH)
    ) u_p_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce_i  (cep),
        .d_i   (p_d),
        .q_o   (p_q)
    );

    dsp_pipe_reg #(
        .WIDTH (1)
    ) u_co_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce_i  (cecarryin),
        .d_i   (co_d),
        .q_o   (co_q)
    );

    generate
        if (PREG != 0) begin : g_p_registered
            assign p = p_q;
        end else begin : g_p_comb
            assign p = p_d;
        end

        if (CARRYOUTREG != 0) begin : g_co_registered
            assign carryout = co_q;
        end else begin : g_co_comb
            assign carryout = co_d;
        end
    endgenerate

    assign pcout     = p;
    assign carryoutf = carryout;

endmodule

`default_nettype wire
